// File: rtl/i2s_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_frame_reader                                                |
// | Purpose  : Reads each completed 256-bit I2S frame out of the bit-circular  |
// |            buffer RAM and emits eight 24-bit samples (one per slot) on a   |
// |            valid/ready stream. Optional frame-skip detection is enabled by |
// |            defining I2S_FRAME_READER_SKIP_DETECT_EN.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2s_frame_reader #(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_i,
    output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
    output logic                       ram_read_en_o,
    input  logic                       ram_read_data_i,
    output logic [23:0]                sample_data_o,
    output logic [2:0]                 sample_channel_o,
    output logic                       sample_valid_o,
    input  logic                       sample_ready_i,
    output logic                       frame_skip_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    state_e                     state_q,     state_d;
    logic [CIRC_BUF_BITS-1:0]   done_idx_q,  done_idx_d;
    logic [CIRC_BUF_BITS-1:0]   cur_frame_q, cur_frame_d;
    logic                       primed_q,    primed_d;
    logic [2:0]                 ch_q,        ch_d;
    logic [4:0]                 bit_cnt_q,   bit_cnt_d;
    // Only bits 0..30 of a slot need storing; bit 31 is taken straight from
    // the RAM in the DRAIN cycle when the full word is assembled.
    logic [30:0]                shreg_q,     shreg_d;
    logic [CIRC_BUF_BITS+7:0]   addr_q,      addr_d;
    logic                       en_q,        en_d;
    logic [23:0]                data_q,      data_d;
    logic [2:0]                 chan_q,      chan_d;
    logic                       valid_q,     valid_d;
    logic [31:0]                w_word;
    logic                       w_new_frame;

`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
    logic                       skip_q,      skip_d;
    logic [CIRC_BUF_BITS-1:0]   w_next_idx;
    assign w_next_idx   = done_idx_q + CIRC_BUF_BITS'(1);
    assign frame_skip_o = skip_q;
`else
    assign frame_skip_o = 1'b0;
`endif

    // Word as it would look after shifting in the bit currently returned by RAM
    assign w_word      = {shreg_q, ram_read_data_i};
    assign w_new_frame = primed_q && (last_good_frame_idx_i != done_idx_q);

    assign ram_read_addr_o  = addr_q;
    assign ram_read_en_o    = en_q;
    assign sample_data_o    = data_q;
    assign sample_channel_o = chan_q;
    assign sample_valid_o   = valid_q;

    // Next-state and registered-output computation for the frame reader FSM
    always_comb begin
        state_d     = state_q;
        done_idx_d  = done_idx_q;
        cur_frame_d = cur_frame_q;
        primed_d    = primed_q;
        ch_d        = ch_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        en_d        = 1'b0;
        data_d      = data_q;
        chan_d      = chan_q;
        valid_d     = valid_q;
`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
        skip_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!primed_q) begin
                    // First look after reset: adopt whatever is current, emit nothing
                    primed_d   = 1'b1;
                    done_idx_d = last_good_frame_idx_i;
                end else if (w_new_frame) begin
                    // Always jump to the newest completed frame
                    cur_frame_d = last_good_frame_idx_i;
                    ch_d        = 3'd0;
                    bit_cnt_d   = 5'd0;
                    en_d        = 1'b1;
                    addr_d      = {last_good_frame_idx_i, 3'd0, 5'd0};
                    state_d     = ST_READ;
`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
                    skip_d      = (last_good_frame_idx_i != w_next_idx);
`endif
                end
            end
            ST_READ: begin
                // The bit strobed last cycle is on the read data port now
                if (bit_cnt_q != 5'd0) begin
                    shreg_d = w_word[30:0];
                end
                if (bit_cnt_q == 5'd31) begin
                    state_d = ST_DRAIN;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    en_d      = 1'b1;
                    addr_d    = {cur_frame_q, ch_q, bit_cnt_q + 5'd1};
                end
            end
            ST_DRAIN: begin
                shreg_d = w_word[30:0];
                data_d  = w_word[31:8];
                chan_d  = ch_q;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            default: begin
                if (sample_ready_i) begin
                    valid_d = 1'b0;
                    if (ch_q != 3'd7) begin
                        ch_d      = ch_q + 3'd1;
                        bit_cnt_d = 5'd0;
                        en_d      = 1'b1;
                        addr_d    = {cur_frame_q, ch_q + 3'd1, 5'd0};
                        state_d   = ST_READ;
                    end else begin
                        done_idx_d = cur_frame_q;
                        state_d    = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            done_idx_q  <= '0;
            cur_frame_q <= '0;
            primed_q    <= 1'b0;
            ch_q        <= 3'd0;
            bit_cnt_q   <= 5'd0;
            shreg_q     <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            data_q      <= 24'd0;
            chan_q      <= 3'd0;
            valid_q     <= 1'b0;
`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
            skip_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            done_idx_q  <= done_idx_d;
            cur_frame_q <= cur_frame_d;
            primed_q    <= primed_d;
            ch_q        <= ch_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            data_q      <= data_d;
            chan_q      <= chan_d;
            valid_q     <= valid_d;
`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
            skip_q      <= skip_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2s_frame_reader                                             |
// | Purpose  : Directed self-checking bench for i2s_frame_reader with a        |
// |            one-cycle-latency bit RAM model.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2s_frame_reader;

`ifdef I2S_FRAME_READER_SKIP_DETECT_EN
    localparam int EXP_SKIP = 1;
`else
    localparam int EXP_SKIP = 0;
`endif

    typedef struct {
        logic        en;
        logic [10:0] addr;
        logic        valid;
        logic [23:0] data;
        logic [2:0]  ch;
        logic        skip;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [2:0]  last_idx;
    logic [10:0] ram_read_addr_o;
    logic        ram_read_en_o;
    logic        ram_rd;
    logic [23:0] sample_data_o;
    logic [2:0]  sample_channel_o;
    logic        sample_valid_o;
    logic        ready;
    logic        frame_skip_o;

    bit          ram [0:2047];
    ent_t        trace [$];
    logic [23:0] got_data [$];
    logic [2:0]  got_ch [$];
    int          got_skips, got_lat, got_timeout;
    int          stall_cycles = 0;
    int          chg_entry = -1;
    logic [2:0]  chg_val = 3'd0;
    int          errors = 0;
    int          checks = 0;

    i2s_frame_reader #(.CIRC_BUF_BITS(3)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .last_good_frame_idx_i (last_idx),
        .ram_read_addr_o       (ram_read_addr_o),
        .ram_read_en_o         (ram_read_en_o),
        .ram_read_data_i       (ram_rd),
        .sample_data_o         (sample_data_o),
        .sample_channel_o      (sample_channel_o),
        .sample_valid_o        (sample_valid_o),
        .sample_ready_i        (ready),
        .frame_skip_o          (frame_skip_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous-read bit RAM: data valid the cycle after the strobe
    always @(posedge clk_i) begin
        if (ram_read_en_o) ram_rd <= ram[ram_read_addr_o];
    end

    function automatic logic [31:0] slot_val(int f, int c);
        if (f == 4 && c == 2) return 32'hA5C3_7E11;
        return (32'h9E37_79B9 * 32'(f * 8 + c + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [23:0] exp_sample(int f, int c);
        logic [31:0] s;
        s = slot_val(f, c);
        return s[31:8];
    endfunction

    // Waits for the first read strobe, then records every cycle until the
    // eighth sample handshake is decided; applies optional stall / index change
    task automatic collect_frame();
        int   waited;
        int   hs;
        ent_t e;
        trace.delete(); got_data.delete(); got_ch.delete();
        got_skips = 0; got_timeout = 0; waited = 0; hs = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!ram_read_en_o && waited < 400);
        got_lat = waited;
        if (!ram_read_en_o) begin
            got_timeout = 1;
            return;
        end
        while (hs < 8 && trace.size() < 2000) begin
            if (trace.size() == chg_entry) last_idx = chg_val;
            if (sample_valid_o && stall_cycles > 0) begin
                ready = 1'b0;
                stall_cycles--;
            end else begin
                ready = 1'b1;
            end
            e.en = ram_read_en_o; e.addr = ram_read_addr_o; e.valid = sample_valid_o;
            e.data = sample_data_o; e.ch = sample_channel_o; e.skip = frame_skip_o;
            trace.push_back(e);
            if (frame_skip_o) got_skips++;
            if (sample_valid_o && ready) begin
                got_data.push_back(sample_data_o);
                got_ch.push_back(sample_channel_o);
                hs++;
            end
            if (hs < 8) @(negedge clk_i);
        end
        if (hs < 8) got_timeout = 1;
        ready = 1'b1;
        chg_entry = -1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; last_idx = 3'd3; ready = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++; if (ram_read_en_o !== 1'b0) begin errors++; $display("FAIL rst_en: got %0b expected 0", ram_read_en_o); end
        checks++; if (ram_read_addr_o !== 11'd0) begin errors++; $display("FAIL rst_addr: got %0h expected 0", ram_read_addr_o); end
        checks++; if (sample_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", sample_valid_o); end
        checks++; if (sample_data_o !== 24'd0) begin errors++; $display("FAIL rst_data: got %0h expected 0", sample_data_o); end
        checks++; if (sample_channel_o !== 3'd0) begin errors++; $display("FAIL rst_chan: got %0d expected 0", sample_channel_o); end
        checks++; if (frame_skip_o !== 1'b0) begin errors++; $display("FAIL rst_skip: got %0b expected 0", frame_skip_o); end
    endtask

    task automatic test_priming();
        int n_en;
        int n_val;
        n_en = 0; n_val = 0;
        rst_ni = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (ram_read_en_o) n_en++;
            if (sample_valid_o) n_val++;
        end
        checks++; if (n_en !== 0) begin errors++; $display("FAIL prime_no_reads: got %0d expected 0", n_en); end
        checks++; if (n_val !== 0) begin errors++; $display("FAIL prime_no_samples: got %0d expected 0", n_val); end
        last_idx = 3'd4;
        collect_frame();
        checks++; if (got_timeout !== 0) begin errors++; $display("FAIL prime_timeout: got %0d expected 0", got_timeout); end
        checks++; if (trace.size() < 32 || trace[0].addr !== 11'h400) begin errors++; $display("FAIL prime_first_addr: got %0h expected 400", trace.size() > 0 ? trace[0].addr : 11'h7FF); end
        checks++; if (trace.size() < 32 || trace[31].addr !== 11'h41F || trace[31].en !== 1'b1) begin errors++; $display("FAIL prime_last_addr: got %0h expected 41f", trace.size() > 31 ? trace[31].addr : 11'h7FF); end
        checks++; if (got_lat !== 1) begin errors++; $display("FAIL prime_latency: got %0d expected 1", got_lat); end
    endtask

    task automatic test_bit_order();
        int n_en;
        n_en = 0;
        foreach (trace[i]) if (trace[i].en) n_en++;
        checks++; if (n_en !== 256) begin errors++; $display("FAIL bits_strobes: got %0d expected 256", n_en); end
        checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL bits_count: got %0d expected 8", got_data.size()); end
        checks++; if (got_data.size() < 3 || got_data[2] !== 24'hA5C37E || got_ch[2] !== 3'd2) begin errors++; $display("FAIL bits_ch2: got %0h expected a5c37e", got_data.size() > 2 ? got_data[2] : 24'h0); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_sample(4, i) || got_ch[i] !== 3'(i)) begin
                errors++; $display("FAIL bits_f4_slot%0d: got ch%0d %0h expected ch%0d %0h", i, got_ch[i], got_data[i], i, exp_sample(4, i));
            end
        end
        // handshake of ch 7 lands on the 273rd edge after the index change
        checks++; if (got_lat + trace.size() !== 273) begin errors++; $display("FAIL bits_frame_cycles: got %0d expected 273", got_lat + trace.size()); end
    endtask

    task automatic test_skip();
        last_idx = 3'd7;
        collect_frame();
        checks++; if (got_skips !== EXP_SKIP) begin errors++; $display("FAIL skip_jump_pulses: got %0d expected %0d", got_skips, EXP_SKIP); end
        checks++; if (trace.size() == 0 || trace[0].skip !== (EXP_SKIP == 1) || trace[0].addr !== 11'h700) begin errors++; $display("FAIL skip_first_strobe: got %0h expected 700", trace.size() > 0 ? trace[0].addr : 11'h7FF); end
        checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL skip_f7_count: got %0d expected 8", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_sample(7, i) || got_ch[i] !== 3'(i)) begin
                errors++; $display("FAIL skip_f7_slot%0d: got %0h expected %0h", i, got_data[i], exp_sample(7, i));
            end
        end
        last_idx = 3'd0;
        collect_frame();
        checks++; if (got_skips !== 0) begin errors++; $display("FAIL skip_wrap_pulses: got %0d expected 0", got_skips); end
        checks++; if (trace.size() == 0 || trace[0].addr !== 11'h000) begin errors++; $display("FAIL skip_wrap_addr: got %0h expected 0", trace.size() > 0 ? trace[0].addr : 11'h7FF); end
        checks++; if (got_data.size() !== 8 || got_data[7] !== exp_sample(0, 7)) begin errors++; $display("FAIL skip_wrap_data: got %0d samples expected 8 with last %0h", got_data.size(), exp_sample(0, 7)); end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        stall_cycles = 10;
        last_idx = 3'd1;
        collect_frame();
        checks++; if (got_timeout !== 0 || trace.size() < 46) begin errors++; $display("FAIL bp_complete: got %0d entries expected 282", trace.size()); end
        else begin
            for (int i = 33; i <= 43; i++) begin
                if (trace[i].valid !== 1'b1 || trace[i].en !== 1'b0 || trace[i].ch !== 3'd0 || trace[i].data !== exp_sample(1, 0)) bad++;
            end
            checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
            checks++; if (trace[44].en !== 1'b1 || trace[44].addr !== 11'h120 || trace[44].valid !== 1'b0) begin errors++; $display("FAIL bp_resume: got en%0b addr %0h expected en1 addr 120", trace[44].en, trace[44].addr); end
        end
        checks++; if (got_skips !== 0) begin errors++; $display("FAIL bp_seq_pulses: got %0d expected 0", got_skips); end
        checks++; if (trace.size() !== 282) begin errors++; $display("FAIL bp_cycles: got %0d expected 282", trace.size()); end
        checks++; if (got_data.size() !== 8 || got_data[0] !== exp_sample(1, 0)) begin errors++; $display("FAIL bp_data: got %0d samples expected 8 with first %0h", got_data.size(), exp_sample(1, 0)); end
    endtask

    task automatic test_index_change();
        chg_entry = 112;
        chg_val = 3'd3;
        last_idx = 3'd2;
        collect_frame();
        checks++; if (got_data.size() !== 8) begin errors++; $display("FAIL chg_f2_count: got %0d expected 8", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_sample(2, i) || got_ch[i] !== 3'(i)) begin
                errors++; $display("FAIL chg_f2_slot%0d: got %0h expected %0h", i, got_data[i], exp_sample(2, i));
            end
        end
        collect_frame();
        checks++; if (trace.size() == 0 || trace[0].addr !== 11'h300) begin errors++; $display("FAIL chg_f3_addr: got %0h expected 300", trace.size() > 0 ? trace[0].addr : 11'h7FF); end
        checks++; if (got_skips !== 0) begin errors++; $display("FAIL chg_f3_pulses: got %0d expected 0", got_skips); end
        checks++; if (got_data.size() !== 8 || got_data[5] !== exp_sample(3, 5)) begin errors++; $display("FAIL chg_f3_data: got %0d samples expected 8", got_data.size()); end
    endtask

    task automatic test_midframe_reset();
        int waited;
        int n_en;
        int n_val;
        waited = 0; n_en = 0; n_val = 0;
        last_idx = 3'd4;
        do begin
            @(negedge clk_i);
            waited++;
        end while (!ram_read_en_o && waited < 400);
        repeat (4 * 34 + 4) @(negedge clk_i);
        checks++; if (ram_read_en_o !== 1'b1 || ram_read_addr_o !== 11'h484) begin errors++; $display("FAIL mrst_in_ch4: got en%0b addr %0h expected en1 addr 484", ram_read_en_o, ram_read_addr_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({ram_read_en_o, sample_valid_o, frame_skip_o} !== 3'b000 || ram_read_addr_o !== 11'd0 || sample_data_o !== 24'd0 || sample_channel_o !== 3'd0) begin
            errors++; $display("FAIL mrst_outputs: got en%0b v%0b addr %0h data %0h expected all 0", ram_read_en_o, sample_valid_o, ram_read_addr_o, sample_data_o);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (12) begin
            @(negedge clk_i);
            if (ram_read_en_o) n_en++;
            if (sample_valid_o) n_val++;
        end
        checks++; if (n_en !== 0 || n_val !== 0) begin errors++; $display("FAIL mrst_reprime: got %0d strobes %0d samples expected 0 0", n_en, n_val); end
        last_idx = 3'd5;
        collect_frame();
        checks++; if (trace.size() == 0 || trace[0].addr !== 11'h500) begin errors++; $display("FAIL mrst_f5_addr: got %0h expected 500", trace.size() > 0 ? trace[0].addr : 11'h7FF); end
        checks++; if (got_skips !== 0) begin errors++; $display("FAIL mrst_f5_pulses: got %0d expected 0", got_skips); end
        checks++; if (got_data.size() !== 8 || got_data[0] !== exp_sample(5, 0) || got_data[7] !== exp_sample(5, 7)) begin errors++; $display("FAIL mrst_f5_data: got %0d samples expected 8 from frame 5", got_data.size()); end
    endtask

    initial begin
        logic [31:0] s;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                s = slot_val(f, c);
                for (int b = 0; b < 32; b++) ram[f * 256 + c * 32 + b] = s[31 - b];
            end
        end
        test_reset();
        test_priming();
        test_bit_order();
        test_skip();
        test_backpressure();
        test_index_change();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
